fifo_burst_reader: RTL

Drains the read port of the cross-clock capture FIFO in the read-clock domain and repacks 16-bit capture words into 64-bit beats, grouped into fixed-length bursts for the downstream memory writer. It sits directly downstream of the FIFO's read side and upstream of the DRAM write path. Bursts start only when enough data is buffered, so the memory writer always sees whole bursts, except for the optional timeout flush.

---
 rtl/fifo_burst_reader_pkg.sv | 18 +
 rtl/fifo_burst_reader_flush_timer.sv | 31 +++
 rtl/fifo_burst_reader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// capture_pkg: shared types and widths for the capture-FIFO read path.
//   state_t   : burst reader sequencing (IDLE / FETCH / PRESENT)
//   WORD_BITS : width of one capture word popped from the FIFO
//   LANES     : capture words packed into one output beat
//   BEAT_BITS : width of one output beat
package capture_pkg;

  localparam int unsigned WORD_BITS = 16;
  localparam int unsigned LANES     = 4;
  localparam int unsigned BEAT_BITS = WORD_BITS * LANES;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT
  } state_t;

endpackage

// File: rtl/fifo_burst_reader_flush_timer.sv
// burst_flush_timer: idle timer that triggers a partial-burst flush.
// Only built when BURST_READER_TIMEOUT_EN is defined.
//   clk, reset : read-domain clock, synchronous active-high reset
//   count_en   : advance the counter this cycle
//   clear      : force the counter back to zero
//   expired    : counter has reached TIMEOUT_CYCLES (holds until cleared)
`ifdef BURST_READER_TIMEOUT_EN
module burst_flush_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  logic [31:0] count;

  assign expired = (count == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains the capture FIFO read port and repacks 16-bit
// words into 64-bit beats grouped into bursts of BURST_BEATS beats. A burst
// starts only once a whole burst is buffered.
// Optional feature macro: BURST_READER_TIMEOUT_EN (idle timeout flushes a
// partial burst, zero-padding the final beat and marking it with out_keep).
//   clk, reset     : read-domain clock, synchronous active-high reset
//   fifo_rd_en     : pop request (data returns the following cycle)
//   fifo_rd_data   : popped capture word
//   fifo_rd_size   : FIFO occupancy (conservative lower bound)
//   fifo_rd_empty  : FIFO empty
//   out_valid/ready: beat handshake toward the memory writer
//   out_data       : beat, lane 0 = oldest word
//   out_keep       : per-lane valid mask
//   out_last       : final beat of a burst
//   burst_count    : completed bursts, wrapping
module fifo_burst_reader
  import capture_pkg::*;
#(
  parameter int unsigned BURST_BEATS    = 8,
  parameter int unsigned SIZE_BITS      = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 fifo_rd_en,
  input  logic [WORD_BITS-1:0] fifo_rd_data,
  input  logic [SIZE_BITS-1:0] fifo_rd_size,
  input  logic                 fifo_rd_empty,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BEAT_BITS-1:0] out_data,
  output logic [LANES-1:0]     out_keep,
  output logic                 out_last,
  output logic [31:0]          burst_count
);

  localparam int unsigned          BURST_WORDS = LANES * BURST_BEATS;
  localparam logic [SIZE_BITS-1:0] THRESHOLD   = SIZE_BITS'(BURST_WORDS);
  localparam logic [SIZE_BITS-1:0] FULL_BEATS  = SIZE_BITS'(BURST_BEATS);
  localparam logic [SIZE_BITS-1:0] ONE         = SIZE_BITS'(1);

  state_t               state;
  logic [SIZE_BITS-1:0] words_left;
  logic [SIZE_BITS-1:0] beats_left;
  logic [2:0]           issue_left;  // pops still to issue for this beat
  logic [1:0]           lane;        // next lane to capture into
  logic                 pop_q;       // a pop was issued last cycle: data is on fifo_rd_data now

  logic                 start_full;
  logic                 start_flush;
  logic [SIZE_BITS-1:0] start_words;
  logic [SIZE_BITS-1:0] start_beats;
  logic [SIZE_BITS-1:0] src_words;
  logic [2:0]           beat_words;

  assign start_full = (state == IDLE) && (fifo_rd_size >= THRESHOLD);

`ifdef BURST_READER_TIMEOUT_EN
  logic timer_count_en;
  logic timer_clear;
  logic timer_expired;

  assign timer_count_en = (state == IDLE) && !fifo_rd_empty && (fifo_rd_size < THRESHOLD);
  assign timer_clear    = (state != IDLE) || fifo_rd_empty;

  burst_flush_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_flush_timer (
    .clk     (clk),
    .reset   (reset),
    .count_en(timer_count_en),
    .clear   (timer_clear),
    .expired (timer_expired)
  );

  // A full burst takes priority; a flush needs at least one word to move.
  assign start_flush = (state == IDLE) && timer_expired && !start_full && (fifo_rd_size != '0);
  assign start_words = start_full ? THRESHOLD  : fifo_rd_size;
  assign start_beats = start_full ? FULL_BEATS : (fifo_rd_size + SIZE_BITS'(3)) >> 2;
`else
  // TIMEOUT_CYCLES and fifo_rd_empty only matter when the flush timer is built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = fifo_rd_empty | (TIMEOUT_CYCLES == 0);
  assign start_flush        = 1'b0;
  assign start_words        = THRESHOLD;
  assign start_beats        = FULL_BEATS;
`endif

  // Words to pop for the beat being started: min(4, words remaining).
  assign src_words  = (state == IDLE) ? start_words : words_left;
  assign beat_words = (src_words >= SIZE_BITS'(4)) ? 3'd4 : src_words[2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      words_left  <= '0;
      beats_left  <= '0;
      issue_left  <= '0;
      lane        <= '0;
      pop_q       <= 1'b0;
      fifo_rd_en  <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      out_keep    <= '0;
      burst_count <= '0;
    end else begin
      pop_q <= fifo_rd_en;
      case (state)
        IDLE: begin
          if (start_full || start_flush) begin
            words_left <= start_words - SIZE_BITS'(beat_words);
            beats_left <= start_beats;
            issue_left <= beat_words - 3'd1;
            fifo_rd_en <= 1'b1;
            lane       <= '0;
            out_data   <= '0;
            out_keep   <= '0;
            state      <= FETCH;
          end
        end
        FETCH: begin
          fifo_rd_en <= (issue_left != '0);
          if (issue_left != '0) begin
            issue_left <= issue_left - 3'd1;
          end
          if (pop_q) begin
            out_data[lane*WORD_BITS +: WORD_BITS] <= fifo_rd_data;
            out_keep[lane]                        <= 1'b1;
            lane                                  <= lane + 2'd1;
            // No pop in flight behind this one: this was the beat's last word.
            if (!fifo_rd_en) begin
              out_valid <= 1'b1;
              out_last  <= (beats_left == ONE);
              state     <= PRESENT;
            end
          end
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            beats_left <= beats_left - ONE;
            if (beats_left == ONE) begin
              burst_count <= burst_count + 32'd1;
              state       <= IDLE;
            end else begin
              words_left <= words_left - SIZE_BITS'(beat_words);
              issue_left <= beat_words - 3'd1;
              fifo_rd_en <= 1'b1;
              lane       <= '0;
              out_data   <= '0;
              out_keep   <= '0;
              state      <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
